// File: rtl/writeback_multi.sv
// writeback_multi: retires WB_LANES results per handshake into a multi-port
// register file, with per-lane bypass, intra-bundle WAW squash and x0 suppression.
// Ports: clk, rst (async, active-low), startSig, beforePipReadyToSend,
//   nextPipReadyToRcv, wb_valid/wb_idx/wb_val with per-field load enables
//   wb_en_valid/wb_en_idx/wb_en_data, curPipReadyToRcv, curPipReadyToSend,
//   bp_idx/bp_val, regFileWriteIdx/Val/En, retire_cnt (WB_RETIRE_CNT_EN only).
// Optional macro: WB_RETIRE_CNT_EN adds the retire_cnt counter and port.
module writeback_multi #(
    parameter int XLEN     = 32,
    parameter int REG_IDX  = 5,
    parameter int AMT_REG  = 32,
    parameter int WB_LANES = 2,
    parameter int CNT_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        startSig,
    input  logic                        beforePipReadyToSend,
    input  logic                        nextPipReadyToRcv,
    input  logic [WB_LANES-1:0]         wb_valid,
    input  logic [WB_LANES*REG_IDX-1:0] wb_idx,
    input  logic [WB_LANES*XLEN-1:0]    wb_val,
    input  logic                        wb_en_valid,
    input  logic                        wb_en_idx,
    input  logic                        wb_en_data,
    output logic                        curPipReadyToRcv,
    output logic                        curPipReadyToSend,
    output logic [WB_LANES*REG_IDX-1:0] bp_idx,
    output logic [WB_LANES*XLEN-1:0]    bp_val,
    output logic [WB_LANES*REG_IDX-1:0] regFileWriteIdx,
    output logic [WB_LANES*XLEN-1:0]    regFileWriteVal,
    output logic [WB_LANES-1:0]         regFileWriteEn
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]            retire_cnt
`endif
);

    if (WB_LANES < 1 || WB_LANES > 4 || CNT_W < 1 ||
        AMT_REG > (1 << REG_IDX)) begin : g_bad_cfg
        $error("writeback_multi: illegal parameter set");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        WAIT_BEF  = 3'b001,
        SENDING   = 3'b010,
        WAIT_SEND = 3'b100
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WB_LANES-1:0]         valid_q;
    logic [WB_LANES*REG_IDX-1:0] idx_q;
    logic [WB_LANES*XLEN-1:0]    val_q;
    logic [WB_LANES-1:0]         act;
    logic                        sending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            idx_q   <= '0;
            val_q   <= '0;
        end else begin
            if (wb_en_valid) valid_q <= wb_valid;
            if (wb_en_idx)   idx_q   <= wb_idx;
            if (wb_en_data)  val_q   <= wb_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (startSig) begin
            state_nxt = beforePipReadyToSend ? SENDING : WAIT_BEF;
        end else begin
            case (state)
                IDLE:     state_nxt = IDLE;
                WAIT_BEF: begin
                    if (beforePipReadyToSend) state_nxt = SENDING;
                end
                SENDING, WAIT_SEND: begin
                    if (nextPipReadyToRcv)
                        state_nxt = beforePipReadyToSend ? SENDING
                                                         : WAIT_BEF;
                    else
                        state_nxt = WAIT_SEND;
                end
                default:  state_nxt = IDLE;
            endcase
        end
    end

    assign sending           = (state == SENDING);
    assign curPipReadyToSend = (state == SENDING) || (state == WAIT_SEND);
    assign curPipReadyToRcv  = (state == WAIT_BEF) ||
                               (curPipReadyToSend && nextPipReadyToRcv);

    // Only the SENDING cycle writes, so a stalled bundle retires once.
    // A higher lane to the same register squashes the lower one.
    always_comb begin
        act = '0;
        for (int k = 0; k < WB_LANES; k++) begin
            act[k] = sending && valid_q[k] &&
                     (idx_q[k*REG_IDX +: REG_IDX] != '0);
            for (int j = k + 1; j < WB_LANES; j++) begin
                if (valid_q[j] &&
                    idx_q[j*REG_IDX +: REG_IDX] ==
                    idx_q[k*REG_IDX +: REG_IDX])
                    act[k] = 1'b0;
            end
        end
    end

    assign regFileWriteEn  = act;
    assign regFileWriteIdx = idx_q;
    assign regFileWriteVal = val_q;

    always_comb begin
        bp_idx = '0;
        bp_val = '0;
        for (int k = 0; k < WB_LANES; k++) begin
            if (act[k]) begin
                bp_idx[k*REG_IDX +: REG_IDX] = idx_q[k*REG_IDX +: REG_IDX];
                bp_val[k*XLEN +: XLEN]       = val_q[k*XLEN +: XLEN];
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] pop;

    always_comb begin
        pop = '0;
        for (int k = 0; k < WB_LANES; k++)
            pop = pop + CNT_W'(act[k]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         retire_cnt <= '0;
        else if (sending) retire_cnt <= retire_cnt + pop;
    end
`endif

endmodule

// File: tb/tb_writeback_multi.sv
// tb_writeback_multi: directed plus randomized bench for writeback_multi,
// checked every cycle against a behavioural model of the stage.
module tb_writeback_multi;

    localparam int L = 2;
    localparam int X = 32;
    localparam int R = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           startSig = 1'b0;
    logic           beforePipReadyToSend = 1'b0;
    logic           nextPipReadyToRcv = 1'b0;
    logic [L-1:0]   wb_valid = '0;
    logic [L*R-1:0] wb_idx = '0;
    logic [L*X-1:0] wb_val = '0;
    logic           wb_en_valid = 1'b0;
    logic           wb_en_idx = 1'b0;
    logic           wb_en_data = 1'b0;
    logic           curPipReadyToRcv;
    logic           curPipReadyToSend;
    logic [L*R-1:0] bp_idx;
    logic [L*X-1:0] bp_val;
    logic [L*R-1:0] regFileWriteIdx;
    logic [L*X-1:0] regFileWriteVal;
    logic [L-1:0]   regFileWriteEn;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0]    retire_cnt;
`endif

    writeback_multi #(
        .XLEN(X), .REG_IDX(R), .AMT_REG(32), .WB_LANES(L), .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .startSig(startSig),
        .beforePipReadyToSend(beforePipReadyToSend),
        .nextPipReadyToRcv(nextPipReadyToRcv),
        .wb_valid(wb_valid),
        .wb_idx(wb_idx),
        .wb_val(wb_val),
        .wb_en_valid(wb_en_valid),
        .wb_en_idx(wb_en_idx),
        .wb_en_data(wb_en_data),
        .curPipReadyToRcv(curPipReadyToRcv),
        .curPipReadyToSend(curPipReadyToSend),
        .bp_idx(bp_idx),
        .bp_val(bp_val),
        .regFileWriteIdx(regFileWriteIdx),
        .regFileWriteVal(regFileWriteVal),
        .regFileWriteEn(regFileWriteEn)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: holding a bundle, its first (writing) cycle,
    // waiting on upstream; plus captured fields and the retire count.
    bit          m_hold;
    bit          m_fresh;
    bit          m_wait;
    logic [L-1:0] m_valid;
    logic [R-1:0] m_idx [L];
    logic [X-1:0] m_val [L];
    logic [31:0]  m_cnt;

    task automatic chk(input string nm, input logic [127:0] a,
                       input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic model_clear();
        m_hold = 0;
        m_fresh = 0;
        m_wait = 0;
        m_valid = '0;
        m_cnt = '0;
        for (int k = 0; k < L; k++) begin
            m_idx[k] = '0;
            m_val[k] = '0;
        end
    endtask

    // Walk from the highest lane down; a register claimed by a higher
    // valid lane blocks lower lanes, x0 never writes.
    function automatic logic [L-1:0] exp_en_f();
        bit seen [32];
        logic [L-1:0] en;
        en = '0;
        for (int i = 0; i < 32; i++) seen[i] = 0;
        for (int k = L - 1; k >= 0; k--) begin
            if (m_fresh && m_valid[k] && m_idx[k] != 0 &&
                !seen[m_idx[k]])
                en[k] = 1'b1;
            if (m_valid[k]) seen[m_idx[k]] = 1;
        end
        return en;
    endfunction

    task automatic model_step();
        logic [L-1:0] en;
        en = exp_en_f();
        for (int k = 0; k < L; k++)
            if (en[k]) m_cnt = m_cnt + 1;
        if (startSig) begin
            m_hold  = beforePipReadyToSend;
            m_fresh = beforePipReadyToSend;
            m_wait  = !beforePipReadyToSend;
        end else if (m_wait) begin
            if (beforePipReadyToSend) begin
                m_wait = 0;
                m_hold = 1;
                m_fresh = 1;
            end
        end else if (m_hold) begin
            if (nextPipReadyToRcv) begin
                m_hold  = beforePipReadyToSend;
                m_fresh = beforePipReadyToSend;
                m_wait  = !beforePipReadyToSend;
            end else begin
                m_fresh = 0;
            end
        end
        if (wb_en_valid) m_valid = wb_valid;
        for (int k = 0; k < L; k++) begin
            if (wb_en_idx)  m_idx[k] = wb_idx[k*R +: R];
            if (wb_en_data) m_val[k] = wb_val[k*X +: X];
        end
    endtask

    task automatic compare();
        logic [L-1:0]   en;
        logic [L*R-1:0] pi, bi;
        logic [L*X-1:0] pv, bv;
        en = exp_en_f();
        pi = '0; bi = '0; pv = '0; bv = '0;
        for (int k = 0; k < L; k++) begin
            pi[k*R +: R] = m_idx[k];
            pv[k*X +: X] = m_val[k];
            if (en[k]) begin
                bi[k*R +: R] = m_idx[k];
                bv[k*X +: X] = m_val[k];
            end
        end
        chk("send", curPipReadyToSend, m_hold);
        chk("rcv", curPipReadyToRcv,
            m_wait | (m_hold & nextPipReadyToRcv));
        chk("wen", regFileWriteEn, en);
        chk("widx", regFileWriteIdx, pi);
        chk("wval", regFileWriteVal, pv);
        chk("bpidx", bp_idx, bi);
        chk("bpval", bp_val, bv);
`ifdef WB_RETIRE_CNT_EN
        chk("cnt", retire_cnt, m_cnt);
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic zero_chk();
        chk("rst_wen", regFileWriteEn, 0);
        chk("rst_send", curPipReadyToSend, 0);
        chk("rst_rcv", curPipReadyToRcv, 0);
        chk("rst_bpval", bp_val, 0);
        chk("rst_wval", regFileWriteVal, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        zero_chk();
        model_clear();
        cyc();
        rst = 1'b1;
    endtask

    task automatic set_all_en(input logic e);
        wb_en_valid = e;
        wb_en_idx = e;
        wb_en_data = e;
    endtask

    initial begin
        model_clear();
        #1;
        zero_chk();
        cyc();
        cyc();
        rst = 1'b1;

        // dual write
        set_all_en(1);
        wb_valid = 2'b11;
        wb_idx = {5'd7, 5'd3};
        wb_val = {32'h12345678, 32'hA5A5A5A5};
        startSig = 1; beforePipReadyToSend = 1; nextPipReadyToRcv = 1;
        cyc();
        chk("dual_wen", regFileWriteEn, 2'b11);
        chk("dual_bpidx", bp_idx, {5'd7, 5'd3});
        chk("dual_bpval", bp_val, {32'h12345678, 32'hA5A5A5A5});
        startSig = 0; beforePipReadyToSend = 0;
        set_all_en(0);
        cyc();
        chk("dual_once", regFileWriteEn, 2'b00);
        chk("dual_waitbef", curPipReadyToRcv, 1);

        // WAW squash
        set_all_en(1);
        wb_idx = {5'd5, 5'd5};
        wb_val = {32'h2, 32'h1};
        beforePipReadyToSend = 1;
        cyc();
        chk("waw_wen", regFileWriteEn, 2'b10);
        chk("waw_bpval", bp_val, {32'h2, 32'h0});
        chk("waw_bpidx", bp_idx, {5'd5, 5'd0});

        // x0 suppression
        wb_valid = 2'b01;
        wb_idx = {5'd6, 5'd0};
        wb_val = {32'h0, 32'hFFFFFFFF};
        cyc();
        chk("x0_wen", regFileWriteEn, 2'b00);
        chk("x0_bpval", bp_val, 0);

        // backpressure
        wb_valid = 2'b11;
        wb_idx = {5'd9, 5'd4};
        wb_val = {32'hCAFE0001, 32'hBEEF0002};
        cyc();
        chk("bp_first_wen", regFileWriteEn, 2'b11);
        nextPipReadyToRcv = 0;
        set_all_en(0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_wen", regFileWriteEn, 2'b00);
            chk("stall_send", curPipReadyToSend, 1);
            chk("stall_rcv", curPipReadyToRcv, 0);
`ifdef WB_RETIRE_CNT_EN
            chk("cnt_five", retire_cnt, 5);
`endif
        end
        nextPipReadyToRcv = 1;
        beforePipReadyToSend = 0;
        #1;
        chk("release_rcv", curPipReadyToRcv, 1);
        cyc();
        chk("waitbef_send", curPipReadyToSend, 0);
        chk("waitbef_rcv", curPipReadyToRcv, 1);

        // reset mid-bundle, then restart
        beforePipReadyToSend = 1;
        cyc();
        chk("pre_rst_wen", regFileWriteEn, 2'b11);
        do_reset();
        set_all_en(1);
        startSig = 1;
        cyc();
        chk("restart_send", curPipReadyToSend, 1);
        chk("restart_wen", regFileWriteEn, 2'b11);
        startSig = 0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            startSig = ($urandom_range(0, 15) == 0);
            beforePipReadyToSend = 1'($urandom_range(0, 1));
            nextPipReadyToRcv = ($urandom_range(0, 3) != 0);
            wb_valid = L'($urandom);
            for (int k = 0; k < L; k++)
                wb_idx[k*R +: R] = R'($urandom_range(0, 7));
            wb_val = {$urandom, $urandom};
            wb_en_valid = ($urandom_range(0, 4) != 0);
            wb_en_idx = ($urandom_range(0, 4) != 0);
            wb_en_data = ($urandom_range(0, 4) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_multi.md
Name: writeback_multi

Overview:
- Parametrised successor of the single-lane writeback stage.
- Retires a bundle of WB_LANES results per handshake into a multi-write-port register file.
- Drives per-lane bypass buses, squashes intra-bundle same-register (WAW) writes, and suppresses x0 writes.
- Sits at the end of the pipeline after memory access, using the standard beforePipReadyToSend / nextPipReadyToRcv handshake.

Parameters:
- XLEN, 32, data width.
- REG_IDX, 5, register index width.
- AMT_REG, 32, number of architectural registers.
- WB_LANES, 2, results per bundle (1..4).
- CNT_W, 32, retire counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- startSig  in  1  pipeline start pulse.
- beforePipReadyToSend  in  1  upstream has a bundle.
- nextPipReadyToRcv  in  1  downstream/commit accepts.
- wb_valid  in  WB_LANES  per-lane result valid.
- wb_idx  in  WB_LANES*REG_IDX  per-lane destination index, lane k at [k*REG_IDX +: REG_IDX].
- wb_val  in  WB_LANES*XLEN  per-lane result data, lane k at [k*XLEN +: XLEN].
- wb_en_valid  in  1  load enable for the wb_valid register.
- wb_en_idx  in  1  load enable for the wb_idx register.
- wb_en_data  in  1  load enable for the wb_val register.
- curPipReadyToRcv  out  1  stage can take a bundle.
- curPipReadyToSend  out  1  stage holds a retired bundle.
- bp_idx  out  WB_LANES*REG_IDX  bypass index per lane, 0 when lane inactive.
- bp_val  out  WB_LANES*XLEN  bypass data per lane, 0 when lane inactive.
- regFileWriteIdx  out  WB_LANES*REG_IDX  regfile write index per port.
- regFileWriteVal  out  WB_LANES*XLEN  regfile write data per port.
- regFileWriteEn  out  WB_LANES  regfile write enable per port.
- retire_cnt  out  CNT_W  retired-write count (present only with the optional feature).

Behaviour:
- Capture registers:
  - On a clk edge, load the valid register from wb_valid if wb_en_valid; the idx register from wb_idx if wb_en_idx; the val register from wb_val if wb_en_data.
  - Each field loads independently of state.
  - rst low clears all capture registers to 0 immediately.
- States:
  - IDLE=3'b000, WAIT_BEF=3'b001, SENDING=3'b010, WAIT_SEND=3'b100.
  - rst low forces IDLE asynchronously.
- Transitions, evaluated each clk edge with rst high:
  - startSig=1 (any state): go to SENDING if beforePipReadyToSend, else WAIT_BEF. startSig takes priority over all other transitions.
  - WAIT_BEF: go to SENDING if beforePipReadyToSend, else stay.
  - SENDING or WAIT_SEND with nextPipReadyToRcv=1: go to SENDING if beforePipReadyToSend, else WAIT_BEF.
  - SENDING or WAIT_SEND with nextPipReadyToRcv=0: go to WAIT_SEND.
  - IDLE with no startSig: stay in IDLE.
  - Any illegal encoding: go to IDLE.
- Handshake outputs:
  - curPipReadyToSend = SENDING | WAIT_SEND.
  - curPipReadyToRcv = WAIT_BEF | (curPipReadyToSend & nextPipReadyToRcv).
  - Both are 0 in IDLE and during reset.
- Lane activity:
  - act[k] = SENDING & valid[k] & (idx[k] != 0) & no higher lane j>k with valid[j] & idx[j]==idx[k].
  - The highest lane wins a WAW conflict; squashed lanes neither write nor bypass.
- Regfile and bypass outputs:
  - regFileWriteEn[k] = act[k].
  - Writes fire only in the SENDING cycle, never in WAIT_SEND, so each bundle writes exactly once even if it stalls.
  - regFileWriteIdx/Val are driven from the capture registers unconditionally.
  - bp_idx[k] and bp_val[k] equal the captured idx/val when act[k], else 0.
- Reset: all outputs read 0 / inactive while rst is low and in IDLE.
- Reset mid-bundle: the in-flight bundle is dropped and no write occurs.
- Latency: a bundle captured on edge N is written and bypassed in the cycle after the edge that enters SENDING; the combinational path from capture registers to outputs is zero cycles.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds a CNT_W-bit retire_cnt register.
  - Each SENDING cycle, retire_cnt increments by popcount(act).
  - The counter wraps modulo 2^CNT_W.
  - rst low clears it to 0.
- Not defined: no retire_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset and start: rst low mid-SENDING with valid=2'b11 -> regFileWriteEn=0 and all outputs 0 immediately. Release rst, pulse startSig with beforePipReadyToSend=1 -> SENDING next cycle.
- Dual write: lanes (idx 3, val 0xA5A5A5A5) and (idx 7, val 0x12345678), both valid, next ready -> regFileWriteEn=2'b11 for exactly one cycle; bp_idx = {7,3}.
- WAW squash: both lanes idx 5, vals 0x1 (lane 0) and 0x2 (lane 1) -> regFileWriteEn=2'b10; bp lane 0 = 0; lane 1 bypasses 0x2.
- x0 suppression: lane 0 idx 0, val 0xFFFFFFFF, valid -> regFileWriteEn[0]=0; bp_val lane 0 = 0.
- Backpressure: nextPipReadyToRcv=0 for 3 cycles after SENDING -> WAIT_SEND held, one write total, curPipReadyToRcv=0. Raise ready with beforePipReadyToSend=0 -> WAIT_BEF, curPipReadyToRcv=1.
- WB_RETIRE_CNT_EN: three bundles retiring 2, 1 and 2 writes -> retire_cnt=5. With CNT_W=3 and 9 writes -> retire_cnt=1.
